// File: rtl/ioctl_loader_pkg.sv
// rtl/ioctl_loader_pkg.sv - shared state encoding and lane-width helper for ioctl_loader
package ioctl_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Number of byte-lane address bits in a memory word (0 for byte-wide memory).
    function automatic int lane_bits(input int word_bytes);
        return (word_bytes <= 1) ? 0 : $clog2(word_bytes);
    endfunction

endpackage

// File: rtl/ioctl_loader_fifo.sv
// rtl/ioctl_loader_fifo.sv - first-word-fall-through word FIFO with occupancy count
module ioctl_loader_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ioctl_loader.sv
// rtl/ioctl_loader.sv - packs ioctl download bytes into word writes with FIFO back-pressure
module ioctl_loader
    import ioctl_loader_pkg::*;
#(
    parameter int          ADDR_W     = 27,
    parameter int          WORD_BYTES = 2,
    parameter int          DEPTH      = 8,
    parameter logic [7:0]  INDEX      = 8'h00,
    parameter logic [7:0]  INDEX_MASK = 8'hFF
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [ADDR_W-1:0]       ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    input  logic [7:0]              ioctl_index,
    output logic                    ioctl_wait,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_data,
    output logic [WORD_BYTES-1:0]   mem_be,
    input  logic                    mem_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int LB = lane_bits(WORD_BYTES);
    localparam int LW = (LB == 0) ? 1 : LB;
    localparam int DW = 8 * WORD_BYTES;
    localparam int EW = ADDR_W + DW + WORD_BYTES;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(WORD_BYTES - 1);

    state_e                  state_q, state_d;
    logic                    dl_q;
    logic                    overflow_q, overflow_d;
    logic                    wait_q, wait_d;
    logic [ADDR_W-1:0]       a_base_q, a_base_d;
    logic [DW-1:0]           a_data_q, a_data_d;
    logic [WORD_BYTES-1:0]   a_be_q, a_be_d, be_cur;

    logic                    rise, start, hit, accept, push, pop, can_push;
    logic [LW-1:0]           lane;
    logic [ADDR_W-1:0]       base;
    logic                    fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_count, count_next;
    logic [EW-1:0]           head;

    assign rise     = ioctl_download & ~dl_q;
    assign start    = rise & (state_q != LOAD);
    assign hit      = ioctl_download & ioctl_wr & (((ioctl_index ^ INDEX) & INDEX_MASK) == 8'h00);
    assign accept   = hit & ~fifo_full;
    assign pop      = ~fifo_empty & mem_ack;
    assign can_push = ~fifo_full | pop;
    assign lane     = LW'(ioctl_addr & LANE_MASK);
    assign base     = ioctl_addr & ~LANE_MASK;

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        a_base_d   = a_base_q;
        a_data_d   = a_data_q;
        push       = 1'b0;
        done       = 1'b0;
        // A fresh download from IDLE starts with an empty assembler.
        be_cur     = (start && state_q == IDLE) ? '0 : a_be_q;
        a_be_d     = be_cur;

        if (start) begin
            overflow_d = 1'b0;
        end
        if (hit && fifo_full) begin
            overflow_d = 1'b1;
        end

        if (accept) begin
            if ((|be_cur) && ((base != a_base_q) || (&be_cur))) begin
                push   = 1'b1;
                be_cur = '0;
            end
            if (be_cur == '0) begin
                a_base_d = base;
            end
            a_data_d[8*lane +: 8] = ioctl_dout;
            a_be_d = be_cur | (WORD_BYTES'(1) << lane);
        end else if ((|be_cur) && can_push && ((&be_cur) || (state_q == FLUSH && !start))) begin
            push   = 1'b1;
            a_be_d = '0;
        end

        case (state_q)
            IDLE:  if (rise) state_d = LOAD;
            LOAD:  if (!ioctl_download) state_d = FLUSH;
            FLUSH: begin
                if (start) begin
                    state_d = LOAD;
                end else if (!(|a_be_q) || push) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (start) begin
                    state_d = LOAD;
                end else if (fifo_empty) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait tracks the occupancy the FIFO will have after this edge.
    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign wait_d     = (count_next >= CW'(DEPTH - 2));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
            wait_q     <= 1'b0;
            a_base_q   <= '0;
            a_data_q   <= '0;
            a_be_q     <= '0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            overflow_q <= overflow_d;
            wait_q     <= wait_d;
            a_base_q   <= a_base_d;
            a_data_q   <= a_data_d;
            a_be_q     <= a_be_d;
        end
    end

    ioctl_loader_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  ({a_base_q, a_data_q, a_be_q}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_req                    = ~fifo_empty;
    assign {mem_addr, mem_data, mem_be} = fifo_empty ? '0 : head;
    assign ioctl_wait                 = wait_q;
    assign busy                       = (state_q != IDLE);
    assign overflow                   = overflow_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// tb/tb_ioctl_loader.sv - randomized and directed checks of ioctl_loader against a queue model
module tb_ioctl_loader;
    localparam int AW    = 27;
    localparam int WB    = 2;
    localparam int DW    = 8 * WB;
    localparam int DEPTH = 4;
    localparam logic [7:0] IDX   = 8'h01;
    localparam logic [7:0] IMASK = 8'hFF;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [WB-1:0] be;
    } word_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = 8'h00;
    logic [7:0]    ioctl_index = 8'h00;
    logic          ioctl_wait;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [WB-1:0] mem_be;
    logic          mem_ack = 1'b0;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk_sys = ~clk_sys;

    ioctl_loader #(
        .ADDR_W     (AW),
        .WORD_BYTES (WB),
        .DEPTH      (DEPTH),
        .INDEX      (IDX),
        .INDEX_MASK (IMASK)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    int    checks = 0;
    int    errors = 0;
    word_t mq[$];
    word_t mpops[$];
    word_t dlog[$];
    int    ph = 0;
    logic [AW-1:0] abase = '0;
    logic [7:0]    abyte [WB];
    logic [WB-1:0] abe = '0;
    bit    ovf = 0, wt = 0, prev_dl = 0;
    int    done_cnt = 0;
    bit    ovf_seen = 0, wait_seen = 0, rnd_ack = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lmask(input logic [WB-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < WB; i++)
            if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic word_t asm_word();
        word_t w;
        w.a  = abase;
        w.be = abe;
        w.d  = '0;
        for (int i = 0; i < WB; i++) w.d[8*i +: 8] = abyte[i];
        return w;
    endfunction

    // Transaction-level reference: a byte assembler and a word queue.
    task automatic model_step();
        bit rise, start, hit, full, pop, pushed, was_valid;
        int pre_n, lane;
        logic [AW-1:0] base;
        pre_n  = mq.size();
        full   = (pre_n == DEPTH);
        pop    = (pre_n > 0) && mem_ack;
        rise   = ioctl_download && !prev_dl;
        start  = rise && (ph != 1);
        hit    = ioctl_download && ioctl_wr && ((ioctl_index & IMASK) == (IDX & IMASK));
        pushed = 0;
        if (start) ovf = 0;
        if (start && ph == 0) abe = '0;
        was_valid = (abe != '0);
        if (pop) begin
            mpops.push_back(mq[0]);
            mq.delete(0);
        end
        lane = int'(ioctl_addr) % WB;
        base = ioctl_addr - AW'(lane);
        if (hit && !full) begin
            if (abe != '0 && (base != abase || (&abe))) begin
                mq.push_back(asm_word());
                pushed = 1;
                abe = '0;
            end
            if (abe == '0) abase = base;
            abyte[lane] = ioctl_dout;
            abe[lane] = 1'b1;
        end else begin
            if (hit) ovf = 1;
            if (abe != '0 && (!full || pop) && ((&abe) || (ph == 2 && !start))) begin
                mq.push_back(asm_word());
                pushed = 1;
                abe = '0;
            end
        end
        case (ph)
            0: if (rise) ph = 1;
            1: if (!ioctl_download) ph = 2;
            2: if (start) ph = 1; else if (!was_valid || pushed) ph = 3;
            default: if (start) ph = 1; else if (pre_n == 0) ph = 0;
        endcase
        wt = (mq.size() >= DEPTH - 2);
        prev_dl = ioctl_download;
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            ph = 0;
            abe = '0;
            abase = '0;
            for (int i = 0; i < WB; i++) abyte[i] = 8'h00;
            ovf = 0;
            wt = 0;
            prev_dl = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk_sys) begin : compare
        word_t h;
        word_t got;
        logic [DW-1:0] m;
        chk("mem_req", 64'(mem_req), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            h = mq[0];
            m = lmask(h.be);
            chk("mem_addr", 64'(mem_addr), 64'(h.a));
            chk("mem_be", 64'(mem_be), 64'(h.be));
            chk("mem_data", 64'(mem_data & m), 64'(h.d & m));
        end
        chk("ioctl_wait", 64'(ioctl_wait), 64'(wt));
        chk("busy", 64'(busy), 64'(ph != 0));
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("done", 64'(done), 64'(ph == 3 && mq.size() == 0 && !(ioctl_download && !prev_dl)));
        if (done) done_cnt++;
        if (overflow) ovf_seen = 1;
        if (ioctl_wait) wait_seen = 1;
        if (mem_req && mem_ack) begin
            got.a = mem_addr;
            got.d = mem_data;
            got.be = mem_be;
            dlog.push_back(got);
        end
    end

    task automatic cyc();
        @(posedge clk_sys);
        #1;
        if (rnd_ack) mem_ack = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [7:0] d, input bit obey);
        int stall;
        stall = 0;
        while (obey && ioctl_wait && stall <= 300) begin
            stall++;
            if (stall == 10 && !rnd_ack) mem_ack = 1'b1;
            cyc();
        end
        if (stall > 300) chk("wait_timeout", 64'(1), 64'(0));
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        cyc();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        cyc();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        cyc();
    endtask

    task automatic wait_idle();
        int n;
        rnd_ack = 0;
        mem_ack = 1'b1;
        n = 0;
        while ((busy || mem_req) && n < 300) begin
            cyc();
            n++;
        end
        chk("idle_timeout", 64'(busy || mem_req), 64'(0));
    endtask

    task automatic clr();
        dlog.delete();
        mpops.delete();
        done_cnt = 0;
        ovf_seen = 0;
        wait_seen = 0;
    endtask

    task automatic chk_log(input string name, input bit use_model, input int i,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WB-1:0] be);
        word_t w;
        logic [DW-1:0] m;
        w.a = '0;
        w.d = '0;
        w.be = '0;
        if (use_model) begin
            if (i < mpops.size()) w = mpops[i];
        end else begin
            if (i < dlog.size()) w = dlog[i];
        end
        m = lmask(be);
        chk({name, "_addr"}, 64'(w.a), 64'(a));
        chk({name, "_be"}, 64'(w.be), 64'(be));
        chk({name, "_data"}, 64'(w.d & m), 64'(d & m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, obey;
        logic [AW-1:0] a;
        logic [7:0] idx;

        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_wait", 64'(ioctl_wait), 64'(0));
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_data", 64'(mem_data), 64'(0));
        chk("rst_be", 64'(mem_be), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        reset_n = 1'b1;
        cyc();

        // Contiguous bytes pack into full words.
        clr();
        mem_ack = 1'b1;
        start_dl(IDX);
        for (int i = 0; i < 4; i++) send(AW'(i), 8'((i + 1) * 17), 1);
        end_dl();
        wait_idle();
        chk("t1_words", 64'(dlog.size()), 64'(2));
        chk_log("t1_w0", 0, 0, 27'd0, 16'h2211, 2'b11);
        chk_log("t1_w1", 0, 1, 27'd2, 16'h4433, 2'b11);
        chk_log("t1_m0", 1, 0, 27'd0, 16'h2211, 2'b11);
        chk("t1_done", 64'(done_cnt), 64'(1));

        // A base change evicts a partial word; flush writes the last one.
        clr();
        start_dl(IDX);
        send(27'd0, 8'h11, 1);
        send(27'd5, 8'h22, 1);
        end_dl();
        wait_idle();
        chk("t2_words", 64'(dlog.size()), 64'(2));
        chk_log("t2_w0", 0, 0, 27'd0, 16'h0011, 2'b01);
        chk_log("t2_w1", 0, 1, 27'd4, 16'h2200, 2'b10);
        chk("t2_done", 64'(done_cnt), 64'(1));

        // Host honours ioctl_wait while the memory stalls.
        clr();
        mem_ack = 1'b0;
        start_dl(IDX);
        for (int i = 0; i < 16; i++) send(AW'(i), 8'(3 * i + 1), 1);
        end_dl();
        wait_idle();
        chk("t3_words", 64'(dlog.size()), 64'(8));
        for (int k = 0; k < 8; k++)
            chk_log("t3_w", 0, k, AW'(2 * k), {8'(6 * k + 4), 8'(6 * k + 1)}, 2'b11);
        chk("t3_wait_seen", 64'(wait_seen), 64'(1));
        chk("t3_ovf_seen", 64'(ovf_seen), 64'(0));

        // Host ignores ioctl_wait: FIFO fills and bytes are dropped.
        clr();
        mem_ack = 1'b0;
        start_dl(IDX);
        for (int i = 0; i < 12; i++) send(AW'(i), 8'(i + 64), 0);
        chk("t4_ovf", 64'(overflow), 64'(1));
        chk("t4_req", 64'(mem_req), 64'(1));
        chk("t4_wait", 64'(ioctl_wait), 64'(1));
        end_dl();
        repeat (3) cyc();
        wait_idle();
        chk("t4_words", 64'(dlog.size()), 64'(5));
        chk_log("t4_w4", 0, 4, 27'd8, 16'h0048, 2'b01);
        chk("t4_ovf_sticky", 64'(overflow), 64'(1));
        start_dl(IDX);
        chk("t4_ovf_clear", 64'(overflow), 64'(0));
        end_dl();
        wait_idle();

        // Index mismatch: no writes, done still pulses.
        clr();
        start_dl(8'h00);
        for (int i = 0; i < 4; i++) send(AW'(i), 8'(i + 5), 1);
        end_dl();
        wait_idle();
        chk("t5_words", 64'(dlog.size()), 64'(0));
        chk("t5_done", 64'(done_cnt), 64'(1));

        // Reset in DRAIN discards queued words.
        clr();
        mem_ack = 1'b0;
        start_dl(IDX);
        for (int i = 0; i < 6; i++) send(AW'(i), 8'(i + 9), 0);
        end_dl();
        repeat (3) cyc();
        chk("t6_busy_pre", 64'(busy), 64'(1));
        chk("t6_req_pre", 64'(mem_req), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("t6_req_rst", 64'(mem_req), 64'(0));
        chk("t6_busy_rst", 64'(busy), 64'(0));
        repeat (2) cyc();
        dlog.delete();
        reset_n = 1'b1;
        mem_ack = 1'b1;
        repeat (10) cyc();
        chk("t6_no_req", 64'(dlog.size()), 64'(0));

        // Randomized downloads with random acknowledge.
        clr();
        for (int it = 0; it < 25; it++) begin
            rnd_ack = 1;
            idx = ($urandom_range(0, 4) == 0) ? 8'h00 : IDX;
            start_dl(idx);
            n = $urandom_range(1, 12);
            a = AW'($urandom_range(0, 63));
            obey = ($urandom_range(0, 3) != 0) ? 1 : 0;
            for (int j = 0; j < n; j++) begin
                send(a, 8'($urandom_range(0, 255)), obey != 0);
                repeat ($urandom_range(0, 2)) cyc();
                case ($urandom_range(0, 7))
                    0: a = AW'($urandom_range(0, 63));
                    1: a = a;
                    default: a = a + AW'(1);
                endcase
            end
            end_dl();
            repeat ($urandom_range(0, 4)) cyc();
            wait_idle();
        end
        chk("rnd_words", 64'(dlog.size()), 64'(mpops.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioctl_loader.md
# ioctl_loader

Parametrised download bridge between the HPS ioctl byte stream and a word-wide memory write port (SDRAM controller or on-chip RAM). Packs byte writes into `WORD_BYTES`-wide little-endian words with byte enables and filters by `ioctl_index`. Buffers words in a FIFO and applies real `ioctl_wait` back-pressure instead of tying it low. Sits in `bocks_top` between the ioctl bus and the memory arbiter; in simulation the same block runs under the Verilator top.

## Interface
- `ADDR_W`, 27: ioctl / memory byte-address width.
- `WORD_BYTES`, 2: memory word width in bytes; one of 1, 2, 4, 8.
- `DEPTH`, 8: FIFO depth in words; power of two, ≥4.
- `INDEX`, 8'h00: `ioctl_index` value accepted.
- `INDEX_MASK`, 8'hFF: bits of `ioctl_index` compared.
- `clk_sys` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download window.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in ADDR_W: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: download target index.
- `ioctl_wait` out 1: back-pressure to the HPS.
- `mem_req` out 1: write request (level).
- `mem_addr` out ADDR_W: word-aligned byte address; low log2(WORD_BYTES) bits are 0.
- `mem_data` out 8*WORD_BYTES: write data; lane n is byte n.
- `mem_be` out WORD_BYTES: byte enables.
- `mem_ack` in 1: the memory has taken the current word.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when a download is fully written.
- `overflow` out 1: sticky flag; a byte was dropped.

## Operation
- A byte is accepted when `ioctl_download && ioctl_wr && (ioctl_index & INDEX_MASK) == (INDEX & INDEX_MASK)` and the FIFO is not full. If the FIFO is full the byte is dropped and `overflow` is set.
- Lane = `ioctl_addr[log2(WORD_BYTES)-1:0]`. Word base = `ioctl_addr` with the lane bits cleared.
- Assembler holds base, data and be; it is valid when any be bit is set.
- An accepted byte into an empty assembler loads the base and sets its lane.
- An accepted byte into a valid assembler with the same base merges; a rewritten lane takes the new byte.
- An accepted byte with a different base, or arriving while the assembler is full (all be set): the current assembler is pushed and the assembler restarts with the new byte.
- A full assembler with no accepted byte that cycle is pushed and cleared.
- At most one push per cycle.
- States:
  - IDLE: `ioctl_download` rising goes to LOAD, clears `overflow` and empties the assembler.
  - LOAD: `ioctl_download` falling goes to FLUSH.
  - FLUSH: pushes the assembler if it is valid (one cycle, waits if the FIFO is full), then goes to DRAIN.
  - DRAIN: when the FIFO is empty, pulse `done` and go to IDLE.
  - `ioctl_download` rising in FLUSH or DRAIN goes to LOAD. No `done` is pulsed for the earlier segment, and queued words are kept.
- FIFO is first-word-fall-through. `mem_req = !empty`, and `mem_addr`, `mem_data` and `mem_be` show the head entry.
- A pop happens on `mem_req && mem_ack`. `mem_ack` while `mem_req` is low is ignored.
- `ioctl_wait` is registered; it is 1 when FIFO count ≥ DEPTH-2, else 0.

## Timing
- Reset (async assert, sync release): `ioctl_wait`, `mem_req`, `mem_addr`, `mem_data`, `mem_be`, `busy`, `done`, `overflow` all 0. FIFO, assembler and state are cleared; a reset mid-transfer discards all queued data.
- Latency: a completed word (last lane written) is on `mem_req` 2 cycles after its last `ioctl_wr`. An evicted partial word appears 1 cycle after the evicting byte.
- Back-to-back: with `mem_ack` held high, one word is popped per cycle.
- `mem_addr`, `mem_data` and `mem_be` are stable while `mem_req && !mem_ack`.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- `ioctl_wait` threshold leaves 2 entries of slack for bytes already in flight.
- `done` is asserted in the cycle after the last pop.

## Structure
- Package `ioctl_loader_pkg`: state enum (IDLE, LOAD, FLUSH, DRAIN) and lane-width constant/function (clog2 of WORD_BYTES).
- Sub-module `ioctl_loader_fifo`: FWFT FIFO parametrised by `DEPTH` and entry width (ADDR_W + 9*WORD_BYTES). Outputs full, empty and count.

## Test plan
- WORD_BYTES=2, `mem_ack`=1: bytes 11,22,33,44 at addresses 0–3 -> words (0, 16'h2211, 2'b11) and (2, 16'h4433, 2'b11); `done` pulses once after `ioctl_download` falls.
- Non-contiguous: 8'h11 at address 0, then 8'h22 at address 5, then download ends -> (0, be 2'b01, lane0=8'h11), then (4, be 2'b10, lane1=8'h22).
- DEPTH=4, `mem_ack`=0, host obeys `ioctl_wait`: 16 bytes -> `ioctl_wait` rises when count reaches 2, `overflow` stays 0; after `mem_ack`=1 all 8 words arrive in address order.
- DEPTH=4, `mem_ack`=0, host ignores `ioctl_wait`: 12 bytes -> 4 words queued, `overflow`=1, extra bytes dropped; the next download start clears `overflow`.
- INDEX=1: download of 4 bytes with `ioctl_index`=0 -> no `mem_req`; `done` still pulses after the window ends.
- Reset mid-DRAIN with 3 words queued -> `mem_req` and `busy` go 0 immediately; after release no further requests.
